// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/
// write-back over a single shared memory port, halts on illegal opcodes
// and keeps cycle / retired-instruction counters for debug display.
//
// Memory handshake (req/ack): mem_req is held high from the first cycle of
// an access until the cycle in which mem_ack is seen high; that cycle
// completes the access (zero-wait ack in the first cycle is legal). mem_we
// and iord are meaningful only while mem_req is high. mem_ack is ignored in
// every state that is not issuing a request. There is no timeout.
module multicycle_ctrl #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic             instr_retired,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t state;
    state_t next_state;

    // zero only qualifies pc_write_cond inside the datapath; the FSM itself
    // never branches on it.
    logic zero_unused;
    assign zero_unused = zero;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; write enables are masked while in reset.
    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        halted        = 1'b0;
        instr_retired = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC-relative target is precomputed into ALUOut here.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:               next_state = S_EXEC_R;
                    OP_I:               next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = S_ADDR;
                    OP_BRANCH:          next_state = S_BRANCH;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            next_state = S_HALT;
                        end else begin
                            instr_retired = 1'b1;
                            next_state    = S_FETCH;
                        end
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b10;
                next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b11;
                next_state = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) begin
                    next_state = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ack) begin
                    instr_retired = 1'b1;
                    next_state    = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                next_state    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                instr_retired = 1'b1;
                next_state    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
        end
    end

    // Free-running debug counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (instr_retired) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Two instances share all inputs: one
// halts on illegal opcodes, the other treats them as NOPs. Each driven cycle
// pushes the hand-written expected control word of both instances plus the
// expected counter values; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    // Control word: {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
    //   pc_src, alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], mem_to_reg,
    //   reg_write, halted, instr_retired}
    localparam logic [16:0] C_RST_FETCH  = 17'b0_0_0_0_0_0_0_00_01_00_0_0_0_0;
    localparam logic [16:0] C_FETCH_WAIT = 17'b1_0_0_0_0_0_0_00_01_00_0_0_0_0;
    localparam logic [16:0] C_FETCH_ACK  = 17'b1_0_0_1_1_0_0_00_01_00_0_0_0_0;
    localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_10_10_00_0_0_0_0;
    localparam logic [16:0] C_DECODE_NOP = 17'b0_0_0_0_0_0_0_10_10_00_0_0_0_1;
    localparam logic [16:0] C_EXEC_R     = 17'b0_0_0_0_0_0_0_01_00_10_0_0_0_0;
    localparam logic [16:0] C_EXEC_I     = 17'b0_0_0_0_0_0_0_01_10_11_0_0_0_0;
    localparam logic [16:0] C_ADDR       = 17'b0_0_0_0_0_0_0_01_10_00_0_0_0_0;
    localparam logic [16:0] C_MEM_RD     = 17'b1_0_1_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [16:0] C_MEM_WR     = 17'b1_1_1_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [16:0] C_MEM_WR_ACK = 17'b1_1_1_0_0_0_0_00_00_00_0_0_0_1;
    localparam logic [16:0] C_WB_ALU     = 17'b0_0_0_0_0_0_0_00_00_00_0_1_0_1;
    localparam logic [16:0] C_WB_MEM     = 17'b0_0_0_0_0_0_0_00_00_00_1_1_0_1;
    localparam logic [16:0] C_BRANCH     = 17'b0_0_0_0_0_1_1_01_00_01_0_0_0_1;
    localparam logic [16:0] C_HALT       = 17'b0_0_0_0_0_0_0_00_00_00_0_0_1_0;
    localparam logic [16:0] C_RST_MEMWR  = 17'b0_0_1_0_0_0_0_00_00_00_0_0_0_0;

    typedef struct packed {
        logic [16:0] ca;
        logic [16:0] cb;
        logic [31:0] cyc;
        logic [31:0] ia;
        logic [31:0] ib;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [6:0] opcode  = OP_R;
    logic       zero    = 1'b0;
    logic       mem_ack = 1'b1;

    logic        a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_pc_write_cond, a_pc_src;
    logic [1:0]  a_alu_src_a, a_alu_src_b, a_alu_op;
    logic        a_mem_to_reg, a_reg_write, a_halted, a_instr_retired;
    logic [31:0] a_cycle_cnt, a_instr_cnt;
    logic        b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_pc_write_cond, b_pc_src;
    logic [1:0]  b_alu_src_a, b_alu_src_b, b_alu_op;
    logic        b_mem_to_reg, b_reg_write, b_halted, b_instr_retired;
    logic [31:0] b_cycle_cnt, b_instr_cnt;

    multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond),
        .pc_src(a_pc_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_op(a_alu_op), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
        .halted(a_halted), .instr_retired(a_instr_retired),
        .cycle_cnt(a_cycle_cnt), .instr_cnt(a_instr_cnt)
    );

    multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
        .pc_src(b_pc_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .halted(b_halted), .instr_retired(b_instr_retired),
        .cycle_cnt(b_cycle_cnt), .instr_cnt(b_instr_cnt)
    );

    logic [16:0] act_a, act_b;
    assign act_a = {a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_pc_write_cond,
                    a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_mem_to_reg,
                    a_reg_write, a_halted, a_instr_retired};
    assign act_b = {b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_pc_write_cond,
                    b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_mem_to_reg,
                    b_reg_write, b_halted, b_instr_retired};

    // Scoreboard
    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cyc = 0, exp_ia = 0, exp_ib = 0;
    int vec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int v);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, v, act, req);
        end
    endtask

    // Monitor: compares the DUT outputs of each driven cycle away from the edge.
    int mon_vec = 0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_t'(exp_q.pop_front());
            check("ctrl_halt_inst", {15'd0, act_a}, {15'd0, e.ca}, mon_vec);
            check("ctrl_nop_inst",  {15'd0, act_b}, {15'd0, e.cb}, mon_vec);
            check("cycle_cnt",      a_cycle_cnt,    e.cyc,         mon_vec);
            check("instr_cnt_halt", a_instr_cnt,    e.ia,          mon_vec);
            check("instr_cnt_nop",  b_instr_cnt,    e.ib,          mon_vec);
            check("cycle_cnt_nop",  b_cycle_cnt,    e.cyc,         mon_vec);
            mon_vec++;
        end
    end

    // Driver: apply one cycle of inputs and queue its expected response.
    task automatic step2(input logic r, input logic [6:0] op, input logic z, input logic ack,
                         input logic [16:0] ea, input logic [16:0] eb);
        exp_t e;
        rst = r; opcode = op; zero = z; mem_ack = ack;
        e.ca = ea; e.cb = eb; e.cyc = exp_cyc; e.ia = exp_ia; e.ib = exp_ib;
        exp_q.push_back(EXP_W'(e));
        vec++;
        @(posedge clk);
        if (r) begin
            exp_cyc = 0; exp_ia = 0; exp_ib = 0;
        end else begin
            exp_cyc = exp_cyc + 1;
            exp_ia  = exp_ia + {31'd0, ea[0]};
            exp_ib  = exp_ib + {31'd0, eb[0]};
        end
        #1;
    endtask

    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic ack,
                        input logic [16:0] e);
        step2(r, op, z, ack, e, e);
    endtask

    initial begin
        // First edge with rst high gives a known state; checks start after it.
        @(posedge clk);
        #1;
        step(1, OP_R, 0, 1, C_RST_FETCH);

        // R-type, zero-wait: 4 cycles
        step(0, OP_R, 0, 1, C_FETCH_ACK);
        step(0, OP_R, 0, 1, C_DECODE);
        step(0, OP_R, 0, 1, C_EXEC_R);
        step(0, OP_R, 0, 1, C_WB_ALU);

        // I-type, mem_ack low outside memory states is irrelevant
        step(0, OP_I, 0, 1, C_FETCH_ACK);
        step(0, OP_I, 1, 0, C_DECODE);
        step(0, OP_I, 0, 0, C_EXEC_I);
        step(0, OP_I, 1, 0, C_WB_ALU);

        // Load with 3 wait cycles in FETCH and in MEM_RD: 11 cycles
        for (int i = 0; i < 3; i++) step(0, OP_LD, 0, 0, C_FETCH_WAIT);
        step(0, OP_LD, 0, 1, C_FETCH_ACK);
        step(0, OP_LD, 0, 1, C_DECODE);
        step(0, OP_LD, 0, 1, C_ADDR);
        for (int i = 0; i < 3; i++) step(0, OP_LD, 0, 0, C_MEM_RD);
        step(0, OP_LD, 0, 1, C_MEM_RD);
        step(0, OP_LD, 0, 1, C_WB_MEM);

        // Store, zero-wait: 4 cycles
        step(0, OP_ST, 0, 1, C_FETCH_ACK);
        step(0, OP_ST, 0, 1, C_DECODE);
        step(0, OP_ST, 0, 1, C_ADDR);
        step(0, OP_ST, 0, 1, C_MEM_WR_ACK);

        // Branch taken and not taken: controls identical either way
        step(0, OP_BR, 1, 1, C_FETCH_ACK);
        step(0, OP_BR, 1, 1, C_DECODE);
        step(0, OP_BR, 1, 1, C_BRANCH);
        step(0, OP_BR, 0, 1, C_FETCH_ACK);
        step(0, OP_BR, 0, 1, C_DECODE);
        step(0, OP_BR, 0, 1, C_BRANCH);

        // Store stalled in MEM_WR, then reset mid-access
        step(0, OP_ST, 0, 1, C_FETCH_ACK);
        step(0, OP_ST, 0, 1, C_DECODE);
        step(0, OP_ST, 0, 1, C_ADDR);
        step(0, OP_ST, 0, 0, C_MEM_WR);
        step(0, OP_ST, 0, 0, C_MEM_WR);
        step(1, OP_ST, 0, 0, C_RST_MEMWR);
        step(0, OP_R, 0, 0, C_FETCH_WAIT);
        step(0, OP_R, 0, 1, C_FETCH_ACK);
        step(0, OP_R, 0, 1, C_DECODE);
        step(0, OP_R, 0, 1, C_EXEC_R);
        step(0, OP_R, 0, 1, C_WB_ALU);

        // Illegal opcode: halting instance stops, NOP instance keeps looping
        step2(0, OP_ILL, 0, 1, C_FETCH_ACK, C_FETCH_ACK);
        step2(0, OP_ILL, 0, 1, C_DECODE,    C_DECODE_NOP);
        step2(0, OP_ILL, 0, 1, C_HALT,      C_FETCH_ACK);
        step2(0, OP_ILL, 0, 1, C_HALT,      C_DECODE_NOP);
        step2(0, OP_ILL, 0, 1, C_HALT,      C_FETCH_ACK);
        step2(0, OP_R,   0, 1, C_HALT,      C_DECODE);
        step2(0, OP_R,   0, 1, C_HALT,      C_EXEC_R);
        step2(1, OP_R,   0, 1, C_HALT,      C_WB_ALU & ~17'b0_0_0_0_0_0_0_00_00_00_0_1_0_1);

        // Both restart from FETCH with cleared counters
        step(0, OP_R, 0, 1, C_FETCH_ACK);
        step(0, OP_R, 0, 1, C_DECODE);
        step(0, OP_R, 0, 1, C_EXEC_R);
        step(0, OP_R, 0, 1, C_WB_ALU);
        step(0, OP_R, 0, 0, C_FETCH_WAIT);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
